// File: rtl/pa_fpu_pkg.sv
// Shared definitions for the FPU command queue: opcodes, register map,
// STATUS/CTRL bit positions, sequencer states and the queued command record.
package pa_fpu;

  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_MUL = 8'h03;
  localparam logic [7:0] OP_DIV = 8'h04;

  // Word addresses in bus-word units.
  localparam logic [5:0] ADDR_A      = 6'd0;
  localparam logic [5:0] ADDR_B      = 6'd4;
  localparam logic [5:0] ADDR_OP     = 6'd8;
  localparam logic [5:0] ADDR_STATUS = 6'd9;
  localparam logic [5:0] ADDR_CTRL   = 6'd10;
  localparam logic [5:0] ADDR_RESULT = 6'd12;

  localparam int STAT_FULL     = 4;
  localparam int STAT_EMPTY    = 5;
  localparam int STAT_OVERRUN  = 6;
  localparam int STAT_OVERFLOW = 7;

  localparam int CTRL_FLUSH        = 0;
  localparam int CTRL_CLR_OVERRUN  = 1;
  localparam int CTRL_CLR_OVERFLOW = 2;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_ISSUE = 2'd1,
    SEQ_WAIT  = 2'd2,
    SEQ_DONE  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  op;
  } fpu_cmd_t;

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Command FIFO. The head stays resident until popped, so a flush can keep
// the in-flight head while discarding everything queued behind it.
module fpu_cmd_fifo
  import pa_fpu::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic       i_flush,
  input  logic       i_keep_head,
  input  fpu_cmd_t   i_wdata,
  output fpu_cmd_t   o_head,
  output logic [3:0] o_count,
  output logic       o_full,
  output logic       o_empty
);

  localparam int PW = $clog2(QDEPTH);

  fpu_cmd_t      r_mem [QDEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [3:0]    r_count;

  logic          w_push_ok;
  logic          w_pop_ok;
  logic          w_keep;
  logic [PW-1:0] w_rd_next;

  assign o_count = r_count;
  assign o_full  = (r_count == 4'(QDEPTH));
  assign o_empty = (r_count == 4'd0);
  assign o_head  = r_mem[r_rd_ptr];

  // A full queue still takes a push when the head leaves in the same cycle.
  assign w_push_ok = i_push && !i_flush && (!o_full || i_pop);
  assign w_pop_ok  = i_pop && !o_empty;
  assign w_keep    = i_keep_head && !w_pop_ok && !o_empty;
  assign w_rd_next = w_pop_ok ? r_rd_ptr + PW'(1) : r_rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      // NOTE: storage is cleared on reset because reset must leave the queue
      // contents at zero; a plain RAM without reset would not guarantee that.
      for (int i = 0; i < QDEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_rd_ptr <= w_rd_next;
      if (i_flush) begin
        r_wr_ptr <= w_rd_next + PW'(w_keep);
        r_count  <= {3'b000, w_keep};
      end else begin
        if (w_push_ok) begin
          r_mem[r_wr_ptr] <= i_wdata;
          r_wr_ptr        <= r_wr_ptr + PW'(1);
        end
        r_count <= r_count + 4'(w_push_ok) - 4'(w_pop_ok);
      end
    end
  end

endmodule

// File: rtl/fpu_cmd_queue.sv
// Host-bus front end for an FPU core: operand staging, command queue,
// single-command sequencer and completion/interrupt flagging.
module fpu_cmd_queue
  import pa_fpu::*;
#(
  parameter int BUS_W  = 8,
  parameter int QDEPTH = 4,
  parameter int OPW    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BUS_W-1:0] databus_in,
  output logic [BUS_W-1:0] databus_out,
  input  logic [5:0]       addr,
  input  logic             cs,
  input  logic             rd,
  input  logic             wr,
  input  logic             end_ack,
  output logic             cmd_end,
  output logic             busy,
  output logic             core_start,
  output logic [OPW-1:0]   core_a,
  output logic [OPW-1:0]   core_b,
  output logic [7:0]       core_op,
  input  logic             core_done,
  input  logic [OPW-1:0]   core_result
);

  localparam int NB = OPW / BUS_W;

  seq_state_t r_state;
  fpu_cmd_t   r_cmd;
  logic [OPW-1:0] r_a, r_b, r_result;
  logic r_wr_prev, r_cmd_end, r_overrun, r_overflow;

  logic w_wr_act, w_wr_acc, w_push, w_ctrl_wr, w_flush, w_pop;
  logic w_in_flight, w_done_evt, w_complete;
  logic w_full, w_empty;
  logic [3:0] w_count;
  logic [7:0] w_status;
  fpu_cmd_t   w_head, w_wdata;

  assign w_wr_act    = !cs && !wr;
  assign w_wr_acc    = w_wr_act && !r_wr_prev;
  assign w_push      = w_wr_acc && (addr == ADDR_OP);
  assign w_ctrl_wr   = w_wr_acc && (addr == ADDR_CTRL);
  assign w_flush     = w_ctrl_wr && databus_in[CTRL_FLUSH];
  assign w_pop       = (r_state == SEQ_DONE);
  assign w_in_flight = (r_state != SEQ_IDLE);
  assign w_done_evt  = (r_state == SEQ_WAIT) && core_done;
  // Completion spans the core_done cycle and the DONE cycle; it beats end_ack.
  assign w_complete  = w_done_evt || w_pop;
  assign w_wdata     = '{a: r_a, b: r_b, op: databus_in[7:0]};

  fpu_cmd_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_flush     (w_flush),
    .i_keep_head (w_in_flight),
    .i_wdata     (w_wdata),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
    end else if (w_wr_acc) begin
      for (int k = 0; k < NB; k++) begin
        if (addr == ADDR_A + 6'(k)) r_a[k*BUS_W +: BUS_W] <= databus_in;
        if (addr == ADDR_B + 6'(k)) r_b[k*BUS_W +: BUS_W] <= databus_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= SEQ_IDLE;
      r_cmd      <= '0;
      r_result   <= '0;
      r_wr_prev  <= 1'b0;
      r_cmd_end  <= 1'b0;
      r_overrun  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      // NOTE: every register here uses <= so all of them see the pre-edge
      // values of each other; blocking = would make results order-dependent.
      r_wr_prev <= w_wr_act;
      case (r_state)
        SEQ_IDLE: begin
          if (!w_empty && !w_flush) begin
            r_cmd   <= w_head;
            r_state <= SEQ_ISSUE;
          end
        end
        SEQ_ISSUE: r_state <= SEQ_WAIT;
        SEQ_WAIT: begin
          if (core_done) begin
            r_result <= core_result;
            r_state  <= SEQ_DONE;
          end
        end
        default: r_state <= SEQ_IDLE;
      endcase

      if (w_complete)   r_cmd_end <= 1'b1;
      else if (end_ack) r_cmd_end <= 1'b0;

      if (w_done_evt && r_cmd_end && !end_ack)
        r_overrun <= 1'b1;
      else if (w_ctrl_wr && databus_in[CTRL_CLR_OVERRUN])
        r_overrun <= 1'b0;

      if (w_push && w_full && !w_pop && !w_flush)
        r_overflow <= 1'b1;
      else if (w_ctrl_wr && databus_in[CTRL_CLR_OVERFLOW])
        r_overflow <= 1'b0;
    end
  end

  always_comb begin
    w_status                = '0;
    w_status[3:0]           = w_count;
    w_status[STAT_FULL]     = w_full;
    w_status[STAT_EMPTY]    = w_empty;
    w_status[STAT_OVERRUN]  = r_overrun;
    w_status[STAT_OVERFLOW] = r_overflow;
  end

  always_comb begin
    // NOTE: defaulting the output first keeps this block free of latches for
    // every address that matches none of the branches below.
    databus_out = '0;
    if (!cs && !rd) begin
      for (int k = 0; k < NB; k++) begin
        if (addr == ADDR_A + 6'(k))      databus_out = r_a[k*BUS_W +: BUS_W];
        if (addr == ADDR_B + 6'(k))      databus_out = r_b[k*BUS_W +: BUS_W];
        if (addr == ADDR_RESULT + 6'(k)) databus_out = r_result[k*BUS_W +: BUS_W];
      end
      if (addr == ADDR_STATUS) databus_out = BUS_W'(w_status);
    end
  end

  assign cmd_end    = r_cmd_end;
  assign busy       = w_in_flight || (w_count != 4'd0);
  assign core_start = (r_state == SEQ_ISSUE);
  assign core_a     = r_cmd.a;
  assign core_b     = r_cmd.b;
  assign core_op    = r_cmd.op;

endmodule

// File: tb/tb_fpu_cmd_queue.sv
// Directed bench for fpu_cmd_queue: an 8-bit-bus instance for the main flows
// and a 16-bit-bus instance for the reset-during-WAIT case.
module tb_fpu_cmd_queue;
  import pa_fpu::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8_n, cs8, rd8, wr8, ack8, end8, busy8, start8, done8;
  logic [7:0]  din8, dout8, op8;
  logic [5:0]  addr8;
  logic [31:0] a8, b8, res8;

  logic        rst16_n, cs16, rd16, wr16, ack16, end16, busy16, start16, done16;
  logic [15:0] din16, dout16;
  logic [7:0]  op16;
  logic [5:0]  addr16;
  logic [31:0] a16, b16, res16;

  int n_checks = 0;
  int n_fail   = 0;
  int starts8  = 0;
  int starts16 = 0;

  fpu_cmd_queue #(.BUS_W(8), .QDEPTH(4), .OPW(32)) dut8 (
    .clk(clk), .rst_n(rst8_n), .databus_in(din8), .databus_out(dout8),
    .addr(addr8), .cs(cs8), .rd(rd8), .wr(wr8), .end_ack(ack8),
    .cmd_end(end8), .busy(busy8), .core_start(start8), .core_a(a8),
    .core_b(b8), .core_op(op8), .core_done(done8), .core_result(res8)
  );

  fpu_cmd_queue #(.BUS_W(16), .QDEPTH(4), .OPW(32)) dut16 (
    .clk(clk), .rst_n(rst16_n), .databus_in(din16), .databus_out(dout16),
    .addr(addr16), .cs(cs16), .rd(rd16), .wr(wr16), .end_ack(ack16),
    .cmd_end(end16), .busy(busy16), .core_start(start16), .core_a(a16),
    .core_b(b16), .core_op(op16), .core_done(done16), .core_result(res16)
  );

  // Count start pulses, one sample per cycle, 1 ns after the edge.
  always @(posedge clk) begin
    #1;
    if (start8)  starts8++;
    if (start16) starts16++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input bit w16, input logic [5:0] a, input logic [15:0] d);
    @(negedge clk);
    if (w16) begin addr16 = a; din16 = d; cs16 = 1'b0; wr16 = 1'b0; end
    else     begin addr8 = a; din8 = d[7:0]; cs8 = 1'b0; wr8 = 1'b0; end
    @(negedge clk);
    cs8 = 1'b1; wr8 = 1'b1; cs16 = 1'b1; wr16 = 1'b1;
  endtask

  task automatic bus_rd(input bit w16, input logic [5:0] a, output logic [15:0] d);
    @(negedge clk);
    if (w16) begin addr16 = a; cs16 = 1'b0; rd16 = 1'b0; #1 d = dout16; end
    else     begin addr8 = a; cs8 = 1'b0; rd8 = 1'b0; #1 d = {8'h00, dout8}; end
    cs8 = 1'b1; rd8 = 1'b1; cs16 = 1'b1; rd16 = 1'b1;
  endtask

  task automatic core_pulse(input bit w16, input logic [31:0] r, input bit ack);
    @(negedge clk);
    if (w16) begin done16 = 1'b1; res16 = r; end
    else     begin done8 = 1'b1; res8 = r; ack8 = ack; end
    @(negedge clk);
    done8 = 1'b0; done16 = 1'b0; ack8 = 1'b0;
  endtask

  task automatic wait_starts(input bit w16, input int target);
    int i = 0;
    while (((w16 ? starts16 : starts8) < target) && (i < 60)) begin
      @(negedge clk);
      i++;
    end
    check("wait_core_start", 32'((w16 ? starts16 : starts8) >= target), 32'd1);
  endtask

  task automatic ack_pulse();
    @(negedge clk); ack8 = 1'b1;
    check("cmd_end_before_ack_edge", end8, 1'b1);
    @(negedge clk); ack8 = 1'b0;
    check("cmd_end_cleared_by_ack", end8, 1'b0);
  endtask

  typedef struct {
    bit         is_wr;
    logic [5:0] addr;
    logic [7:0] data;   // write data, or expected read data
  } vec_t;

  vec_t vecs[$];
  logic [7:0] exp_res[4] = '{8'h00, 8'h00, 8'hC0, 8'hC0};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rv;
    int s0;

    {cs8, rd8, wr8, cs16, rd16, wr16} = '1;
    {ack8, done8, ack16, done16} = '0;
    din8 = '0; din16 = '0; addr8 = '0; addr16 = '0; res8 = '0; res16 = '0;
    rst8_n = 1'b0; rst16_n = 1'b0;
    repeat (3) @(negedge clk);
    rst8_n = 1'b1; rst16_n = 1'b1;

    check("rst_core_start", start8, 1'b0);
    check("rst_core_a", a8, 32'h0);
    check("rst_core_b", b8, 32'h0);
    check("rst_core_op", op8, 8'h0);
    check("rst_cmd_end", end8, 1'b0);
    check("rst_busy", busy8, 1'b0);
    check("rst_databus_out", dout8, 8'h0);

    // Register map: staging writes, readback, unmapped and write-only slots.
    vecs.push_back('{1'b0, ADDR_STATUS, 8'h20});
    vecs.push_back('{1'b1, 6'd0, 8'h00});
    vecs.push_back('{1'b1, 6'd1, 8'h00});
    vecs.push_back('{1'b1, 6'd2, 8'h00});
    vecs.push_back('{1'b1, 6'd3, 8'h40});
    vecs.push_back('{1'b1, 6'd4, 8'h00});
    vecs.push_back('{1'b1, 6'd5, 8'h00});
    vecs.push_back('{1'b1, 6'd6, 8'h00});
    vecs.push_back('{1'b1, 6'd7, 8'h41});
    vecs.push_back('{1'b0, 6'd3, 8'h40});
    vecs.push_back('{1'b0, 6'd7, 8'h41});
    vecs.push_back('{1'b0, 6'd0, 8'h00});
    vecs.push_back('{1'b1, 6'd11, 8'hFF});
    vecs.push_back('{1'b0, 6'd11, 8'h00});
    vecs.push_back('{1'b0, 6'd63, 8'h00});
    vecs.push_back('{1'b0, ADDR_OP, 8'h00});
    vecs.push_back('{1'b0, ADDR_CTRL, 8'h00});
    vecs.push_back('{1'b0, ADDR_RESULT, 8'h00});
    vecs.push_back('{1'b0, ADDR_STATUS, 8'h20});
    foreach (vecs[i]) begin
      if (vecs[i].is_wr) bus_wr(1'b0, vecs[i].addr, {8'h00, vecs[i].data});
      else begin
        bus_rd(1'b0, vecs[i].addr, rv);
        check($sformatf("vec%0d_rd_addr%0d", i, vecs[i].addr), rv, {24'h0, vecs[i].data});
      end
    end

    // First command: 2-cycle latency from the OP write to core_start.
    bus_wr(1'b0, ADDR_OP, {8'h00, OP_SUB});
    check("start_not_yet", start8, 1'b0);
    check("busy_after_push", busy8, 1'b1);
    @(negedge clk);
    check("start_latency2", start8, 1'b1);
    check("issue_core_a", a8, 32'h4000_0000);
    check("issue_core_b", b8, 32'h4100_0000);
    check("issue_core_op", op8, OP_SUB);
    @(negedge clk);
    check("start_single_cycle", start8, 1'b0);
    check("wait_core_op_held", op8, OP_SUB);
    core_pulse(1'b0, 32'hC0C0_0000, 1'b0);
    @(negedge clk);
    check("first_cmd_end", end8, 1'b1);
    check("first_busy_clear", busy8, 1'b0);
    check("first_start_count", starts8, 32'd1);
    for (int k = 0; k < 4; k++) begin
      bus_rd(1'b0, ADDR_RESULT + 6'(k), rv);
      check($sformatf("result_byte%0d", k), rv, {24'h0, exp_res[k]});
    end

    // core_done outside WAIT must not touch the result or the flags.
    core_pulse(1'b0, 32'hDEAD_BEEF, 1'b0);
    bus_rd(1'b0, ADDR_RESULT + 6'd3, rv);
    check("stray_done_result", rv, 32'hC0);
    bus_rd(1'b0, ADDR_STATUS, rv);
    check("stray_done_status", rv, 32'h20);
    ack_pulse();

    // Stalled core: five pushes into a depth-4 queue.
    s0 = starts8;
    for (int i = 0; i < 5; i++) bus_wr(1'b0, ADDR_OP, {8'h00, OP_ADD});
    check("stall_one_start", starts8, s0 + 1);
    bus_rd(1'b0, ADDR_STATUS, rv);
    check("full_overflow_status", rv, 32'h94);
    for (int i = 0; i < 4; i++) begin
      wait_starts(1'b0, s0 + 1 + i);
      core_pulse(1'b0, 32'h3F80_0000 + i, 1'b1);
    end
    repeat (10) @(negedge clk);
    check("drain_start_count", starts8, s0 + 4);
    check("drain_cmd_end", end8, 1'b1);
    bus_rd(1'b0, ADDR_STATUS, rv);
    check("drain_status", rv, 32'hA0);
    bus_rd(1'b0, ADDR_RESULT, rv);
    check("drain_last_result", rv, 32'h03);
    bus_wr(1'b0, ADDR_CTRL, 16'h0004);
    bus_rd(1'b0, ADDR_STATUS, rv);
    check("clr_overflow_status", rv, 32'h20);

    // end_ack coinciding with core_done, then an unacked completion.
    s0 = starts8;
    bus_wr(1'b0, ADDR_OP, {8'h00, OP_ADD});
    wait_starts(1'b0, s0 + 1);
    core_pulse(1'b0, 32'h1111_1111, 1'b1);
    check("ack_race_cmd_end", end8, 1'b1);
    @(negedge clk);
    check("ack_race_cmd_end_hold", end8, 1'b1);
    bus_rd(1'b0, ADDR_STATUS, rv);
    check("ack_race_no_overrun", rv, 32'h20);
    bus_wr(1'b0, ADDR_OP, {8'h00, OP_ADD});
    wait_starts(1'b0, s0 + 2);
    core_pulse(1'b0, 32'h2222_2222, 1'b0);
    @(negedge clk);
    bus_rd(1'b0, ADDR_STATUS, rv);
    check("overrun_set", rv, 32'h60);
    bus_wr(1'b0, ADDR_CTRL, 16'h0002);
    bus_rd(1'b0, ADDR_STATUS, rv);
    check("overrun_cleared", rv, 32'h20);
    ack_pulse();

    // Flush during WAIT keeps only the in-flight command.
    s0 = starts8;
    bus_wr(1'b0, ADDR_OP, {8'h00, OP_MUL});
    bus_wr(1'b0, ADDR_OP, {8'h00, OP_ADD});
    bus_wr(1'b0, ADDR_OP, {8'h00, OP_DIV});
    bus_rd(1'b0, ADDR_STATUS, rv);
    check("three_queued_status", rv, 32'h03);
    check("inflight_op", op8, OP_MUL);
    bus_wr(1'b0, ADDR_CTRL, 16'h0001);
    bus_rd(1'b0, ADDR_STATUS, rv);
    check("flush_keeps_head", rv, 32'h01);
    core_pulse(1'b0, 32'h1234_5678, 1'b0);
    repeat (20) @(negedge clk);
    check("flush_no_more_starts", starts8, s0 + 1);
    check("flush_busy_clear", busy8, 1'b0);
    check("flush_cmd_end", end8, 1'b1);
    bus_rd(1'b0, ADDR_STATUS, rv);
    check("flush_empty_status", rv, 32'h20);
    bus_rd(1'b0, ADDR_RESULT, rv);
    check("flush_inflight_result", rv, 32'h78);

    // 16-bit bus: reset while WAIT abandons the command.
    bus_wr(1'b1, 6'd0, 16'h0000);
    bus_wr(1'b1, 6'd1, 16'h3F80);
    bus_wr(1'b1, 6'd4, 16'h0000);
    bus_wr(1'b1, 6'd5, 16'h4000);
    bus_rd(1'b1, 6'd1, rv);
    check("w16_a_hi_readback", rv, 32'h3F80);
    bus_rd(1'b1, 6'd2, rv);
    check("w16_addr2_zero", rv, 32'h0);
    bus_rd(1'b1, ADDR_STATUS, rv);
    check("w16_status_idle", rv, 32'h0020);
    bus_wr(1'b1, ADDR_OP, {8'h00, OP_ADD});
    wait_starts(1'b1, 1);
    check("w16_core_a", a16, 32'h3F80_0000);
    check("w16_core_b", b16, 32'h4000_0000);
    check("w16_core_op", op16, OP_ADD);
    @(negedge clk);
    rst16_n = 1'b0;
    @(negedge clk);
    check("w16_rst_start", start16, 1'b0);
    check("w16_rst_a", a16, 32'h0);
    check("w16_rst_b", b16, 32'h0);
    check("w16_rst_op", op16, 8'h0);
    check("w16_rst_cmd_end", end16, 1'b0);
    check("w16_rst_busy", busy16, 1'b0);
    check("w16_rst_dout", dout16, 16'h0);
    rst16_n = 1'b1;
    core_pulse(1'b1, 32'h4040_0000, 1'b0);
    repeat (3) @(negedge clk);
    check("w16_late_done_cmd_end", end16, 1'b0);
    check("w16_late_done_busy", busy16, 1'b0);
    check("w16_single_start", starts16, 32'd1);
    bus_rd(1'b1, ADDR_RESULT, rv);
    check("w16_result_zero", rv, 32'h0);
    bus_rd(1'b1, 6'd2, rv);
    check("w16_addr2_after_rst", rv, 32'h0);
    bus_rd(1'b1, 6'd1, rv);
    check("w16_staging_cleared", rv, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
